// File: rtl/mem_pkg.sv
// Shared definitions for the load/store alignment unit: size codes,
// FSM states and the lane/alignment helpers.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10,
    ST_ERR  = 2'b11
  } state_t;

  // Byte always legal, half needs an even address, word needs addr[1:0]=00.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: is_aligned = 1'b1;
      SZ_HALF: is_aligned = ~lane[0];
      SZ_WORD: is_aligned = (lane == 2'b00);
      default: is_aligned = 1'b0;
    endcase
  endfunction

  // Byte enables for a legal access; loads use the same mask.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: byte_en = 4'b0001 << lane;
      SZ_HALF: byte_en = 4'b0011 << {lane[1], 1'b0};
      SZ_WORD: byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  endfunction

  // Replicate the narrow store value across every lane so the enables pick it.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: store_data = {4{wdata[7:0]}};
      SZ_HALF: store_data = {2{wdata[15:0]}};
      default: store_data = wdata;
    endcase
  endfunction

endpackage

// File: rtl/mem_align_load_extend.sv
// Combinational load lane extraction and sign/zero extension.
// Kept standalone so an uncached load path can reuse it.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_sign;

  // Pick the addressed field and extend it from its top bit unless unsigned.
  always_comb begin
    w_byte   = i_rdata[{i_addr, 3'b000} +: 8];
    w_half   = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
    w_sign   = 1'b0;
    o_result = i_rdata;
    case (i_size)
      SZ_BYTE: begin
        w_sign   = ~i_unsigned & w_byte[7];
        o_result = {{24{w_sign}}, w_byte};
      end
      SZ_HALF: begin
        w_sign   = ~i_unsigned & w_half[15];
        o_result = {{16{w_sign}}, w_half};
      end
      default: o_result = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_align.sv
// Load/store alignment unit: latches an op on accept, runs the memory
// req/ack handshake, extends load data, and traps misaligned/illegal ops
// without issuing a memory request.
module mem_align
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  input  logic              op_write,
  input  logic [1:0]        op_size,
  input  logic              op_unsigned,
  input  logic [ADDR_W-1:0] op_addr,
  input  logic [31:0]       op_wdata,
  output logic              op_ready,
  output logic              stall,
  output logic              rd_valid,
  output logic [31:0]       rd_data,
  output logic              addr_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  state_t            r_state;
  logic              r_we;
  logic [3:0]        r_be;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [1:0]        r_size;
  logic [1:0]        r_lane;
  logic              r_unsigned;
  logic [31:0]       r_rd_data;
  logic [31:0]       w_ext;

  load_extend u_ext (
    .i_rdata    (mem_rdata),
    .i_addr     (r_lane),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_result   (w_ext)
  );

  // Handshake FSM; op fields are captured on accept and held through REQ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_we       <= 1'b0;
      r_be       <= 4'b0000;
      r_addr     <= '0;
      r_wdata    <= 32'h0;
      r_size     <= SZ_BYTE;
      r_lane     <= 2'b00;
      r_unsigned <= 1'b0;
      r_rd_data  <= 32'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (op_valid) begin
            r_size     <= op_size;
            r_lane     <= op_addr[1:0];
            r_unsigned <= op_unsigned;
            if (is_aligned(op_size, op_addr[1:0])) begin
              r_we    <= op_write;
              r_be    <= byte_en(op_size, op_addr[1:0]);
              r_addr  <= {op_addr[ADDR_W-1:2], 2'b00};
              r_wdata <= op_write ? store_data(op_size, op_wdata) : 32'h0;
              r_state <= ST_REQ;
            end else begin
              // Memory-facing registers are left alone on a trap.
              r_state <= ST_ERR;
            end
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            if (!r_we) r_rd_data <= w_ext;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Status outputs decode straight from state so reset clears them at once.
  assign op_ready  = (r_state == ST_IDLE);
  assign mem_req   = (r_state == ST_REQ);
  assign rd_valid  = (r_state == ST_DONE) & ~r_we;
  assign addr_err  = (r_state == ST_ERR);
  assign stall     = op_valid & ~((r_state == ST_DONE) | (r_state == ST_ERR));
  assign mem_we    = r_we;
  assign mem_be    = r_be;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign rd_data   = r_rd_data;

endmodule

// File: doc/mem_align.md
# mem_align

Load/store alignment unit between the execute stage and the data memory port. Stores: narrows 32-bit register data to byte/halfword/word writes, with lane-replicated write data and byte enables. Loads: extracts the addressed lane from the returned word and sign- or zero-extends it back to 32 bits. A small FSM runs the memory request/acknowledge handshake, stalls the pipeline until completion, and traps misaligned or illegal accesses without touching memory.

## Interface
Parameters:
- ADDR_W, 32, byte address width; mem_addr carries the word-aligned address.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- op_valid  in  1  pipeline presents a memory op; held stable while stall=1.
- op_write  in  1  1=store, 0=load.
- op_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- op_unsigned  in  1  loads only: 1=zero-extend, 0=sign-extend.
- op_addr  in  ADDR_W  byte address.
- op_wdata  in  32  store data; low byte/half used for narrow stores.
- op_ready  out  1  unit idle, can accept an op.
- stall  out  1  hold the pipeline.
- rd_valid  out  1  one-cycle pulse: rd_data valid.
- rd_data  out  32  extended load result.
- addr_err  out  1  one-cycle pulse: misaligned or illegal op.
- mem_req  out  1  memory request.
- mem_we  out  1  write request.
- mem_be  out  4  byte enables, bit k = byte lane k.
- mem_addr  out  ADDR_W  {op_addr[ADDR_W-1:2], 2'b00}.
- mem_wdata  out  32  lane-replicated store data.
- mem_ack  in  1  memory done; mem_rdata valid the same cycle for loads.
- mem_rdata  in  32  read word.

## Operation
- States: IDLE, REQ, DONE, ERR. Reset state IDLE.
- Byte order is little-endian: lane k = bits [8k+7:8k], lane index = op_addr[1:0].
- Accept: op_valid & op_ready. Everything needed is latched into registers on the accept edge.
- Alignment: byte always legal. Halfword needs addr[0]=0. Word needs addr[1:0]=00. op_size 11 is always illegal.
- Legal op: IDLE→REQ. Illegal op: IDLE→ERR with no mem_req.
- mem_be: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<{addr[1],1'b0}; word = 4'b1111. Loads drive the same be.
- mem_wdata: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata. Loads drive 0.
- REQ: mem_req=1 with mem_we/mem_be/mem_addr/mem_wdata held constant. Leave for DONE when mem_ack=1.
- Load capture: mem_rdata is extended into a register on the ack edge.
  - Byte selects lane addr[1:0].
  - Half selects bits [31:16] when addr[1]=1, else [15:0].
  - Sign-extend from the top bit of the selected field unless op_unsigned=1.
- DONE: rd_valid=1 for loads only (0 for stores). Then DONE→IDLE.
- ERR: addr_err=1 for one cycle. Then ERR→IDLE.
- op_ready = (state==IDLE).
- stall = op_valid & ~(state==DONE | state==ERR). The pipeline advances after the DONE/ERR cycle.
- mem_ack outside REQ is ignored.
- Reset mid-operation: mem_req drops immediately (asynchronous), FSM returns to IDLE, and the pending op is lost.

## Timing
- All outputs registered or decoded from state, except stall, which is combinational on op_valid.
- Reset values:
  - mem_req, mem_we, rd_valid, addr_err = 0.
  - mem_be = 0; mem_addr, mem_wdata, rd_data = 0.
  - op_ready = 1.
- Accept at edge T: mem_req high from cycle T+1.
- If ack arrives in cycle T+n (n≥1): DONE in cycle T+n+1, op_ready again at T+n+2.
- Minimum op latency is 3 cycles, accept to next accept.
- Illegal op accepted at T: addr_err high in cycle T+1, op_ready at T+2.
- rd_data holds its value until the next load completes.

## Structure
- Shared package mem_pkg holds:
  - size codes SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - FSM state enum;
  - function is_aligned(size, addr[1:0]).
- One sub-module, load_extend: combinational extraction and extension, with inputs rdata, addr[1:0], size, unsigned and output 32-bit result. It is reused by any later uncached load path.

## Test plan
- sb, addr 0x1003, wdata 0x000000A5 → mem_be=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x1000, mem_we=1; ack after 2 cycles → DONE with rd_valid=0.
- lb then lbu, addr 0x2001, mem_rdata=0x1234_80FF → lb rd_data=0xFFFFFF80; lbu rd_data=0x00000080; each rd_valid is a single pulse.
- lh, addr 0x2002, mem_rdata=0x8001_7FFF → mem_be=1100, rd_data=0xFFFF8001. Same with lhu → 0x00008001.
- lw at 0x3002, sh at 0x3001, op_size=11 → addr_err pulse one cycle after accept, no mem_req ever asserted, op_ready back next cycle.
- sw at 0x4000 with ack held low 10 cycles → mem_req and all mem_* outputs stable for 11 cycles, stall=1 throughout; a stray mem_ack in IDLE has no effect.
- rst asserted mid-REQ → mem_req=0 within the same cycle, op_ready=1, no rd_valid; the next op completes normally.
